// File: rtl/xor_bist_checker.sv
// ---------------------------------------------------------------------------
// xor_bist_checker
//
// Built-in self test for a two-input XOR gate. The block drives the four
// input vectors 00, 01, 10, 11 onto the gate under test. After each vector
// change it waits SETTLE_CYCLES clock cycles, then spends one CHECK cycle
// and compares the gate response with a^b on the edge that ends CHECK.
// Mismatches are counted and recorded per vector. The results stay visible
// in DONE until the next accepted start or reset.
//
// Parameters
//   SETTLE_CYCLES  settle cycles after each vector update (1..255)
//
// Optional feature (compile-time macro)
//   XOR_BIST_ABORT_EN  when defined, the first mismatching vector ends the
//                      run at once. a/b keep the failing vector and
//                      err_count is 1. When undefined, all four vectors are
//                      always checked.
//
// Ports
//   clk        in   clock; all state changes on its rising edge
//   reset      in   synchronous, active-high reset
//   start      in   run request; sampled only in IDLE or DONE
//   dut_out    in   response of the XOR under test
//   a, b       out  registered stimulus bits (vector index = {a,b})
//   busy       out  high in SETTLE or CHECK
//   done       out  high in DONE
//   pass       out  high in DONE when no vector mismatched
//   err_count  out  mismatching vectors in the last run (0..4)
//   fail_vec   out  bit i set when vector i mismatched
// ---------------------------------------------------------------------------
module xor_bist_checker #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       dut_out,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Counter value on which SETTLE hands over to CHECK.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [1:0] idx_reg,   idx_next;
    logic [7:0] cnt_reg,   cnt_next;
    logic       a_reg,     a_next;
    logic       b_reg,     b_next;
    logic [2:0] err_reg,   err_next;
    logic [3:0] fail_reg,  fail_next;

    // One-hot decode of the current vector index. It is used to set the
    // matching fail_vec bit on a mismatch.
    logic [3:0] vec_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_vec_sel
            localparam logic [1:0] VEC = 2'(gi);
            assign vec_sel[gi] = (idx_reg == VEC);
        end
    endgenerate

    // The response is only meaningful in CHECK. Outside CHECK, dut_out never
    // reaches the result registers.
    logic       mismatch;
    logic [1:0] idx_inc;

    assign mismatch = (dut_out != (a_reg ^ b_reg));
    assign idx_inc  = idx_reg + 2'd1;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= 2'd0;
            cnt_reg   <= 8'd0;
            a_reg     <= 1'b0;
            b_reg     <= 1'b0;
            err_reg   <= 3'd0;
            fail_reg  <= 4'd0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            err_reg   <= err_next;
            fail_reg  <= fail_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        err_next   = err_reg;
        fail_next  = fail_reg;

        case (state_reg)
            IDLE, DONE: begin
                // A new run wipes all results from the previous run on the
                // same edge that launches vector 00.
                if (start) begin
                    state_next = SETTLE;
                    idx_next   = 2'd0;
                    cnt_next   = 8'd0;
                    a_next     = 1'b0;
                    b_next     = 1'b0;
                    err_next   = 3'd0;
                    fail_next  = 4'd0;
                end
            end

            SETTLE: begin
                cnt_next = cnt_reg + 8'd1;
                if (cnt_reg == SETTLE_LAST) begin
                    state_next = CHECK;
                end
            end

            CHECK: begin
                if (mismatch) begin
                    // Saturate the count so it cannot wrap. Four vectors
                    // already bound it to 4.
                    if (err_reg < 3'd4) begin
                        err_next = err_reg + 3'd1;
                    end
                    fail_next = fail_reg | vec_sel;
                end
`ifdef XOR_BIST_ABORT_EN
                // Stop at the first failing vector and leave it on a/b.
                if (mismatch || (idx_reg == 2'd3)) begin
                    state_next = DONE;
                end else begin
                    state_next = SETTLE;
                    idx_next   = idx_inc;
                    cnt_next   = 8'd0;
                    a_next     = idx_inc[1];
                    b_next     = idx_inc[0];
                end
`else
                if (idx_reg == 2'd3) begin
                    // a/b stay at 1,1 in DONE.
                    state_next = DONE;
                end else begin
                    state_next = SETTLE;
                    idx_next   = idx_inc;
                    cnt_next   = 8'd0;
                    a_next     = idx_inc[1];
                    b_next     = idx_inc[0];
                end
`endif
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign a         = a_reg;
    assign b         = b_reg;
    assign busy      = (state_reg == SETTLE) || (state_reg == CHECK);
    assign done      = (state_reg == DONE);
    assign pass      = (state_reg == DONE) && (err_reg == 3'd0);
    assign err_count = err_reg;
    assign fail_vec  = fail_reg;

endmodule

// File: tb/tb_xor_bist_checker.sv
// ---------------------------------------------------------------------------
// tb_xor_bist_checker
//
// Directed bench for xor_bist_checker. It uses two instances:
//   dut   SETTLE_CYCLES=4, gate model selectable (xor / stuck-0 / xnor)
//   dut1  SETTLE_CYCLES=1, gate model fixed to xnor
// Expected values are hand-derived from the cycle timing. At SETTLE_CYCLES
// S, each vector occupies S+1 edges, so a full run lasts 4*(S+1) edges.
// ---------------------------------------------------------------------------
module tb_xor_bist_checker;

    logic       clk;
    logic       reset;

    logic       start;
    logic       dut_out;
    logic       a, b, busy, done, pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;

    logic       start1;
    logic       dut_out1;
    logic       a1, b1, busy1, done1, pass1;
    logic [2:0] err_count1;
    logic [3:0] fail_vec1;

    // 0: correct xor, 1: output stuck at 0, 2: xnor
    int         gate_mode;

    int         n_checks;
    int         n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        dut_out = a ^ b;
        if (gate_mode == 1) dut_out = 1'b0;
        if (gate_mode == 2) dut_out = ~(a ^ b);
    end

    assign dut_out1 = ~(a1 ^ b1);

    xor_bist_checker #(.SETTLE_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dut_out   (dut_out),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_vec  (fail_vec)
    );

    xor_bist_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start1),
        .dut_out   (dut_out1),
        .a         (a1),
        .b         (b1),
        .busy      (busy1),
        .done      (done1),
        .pass      (pass1),
        .err_count (err_count1),
        .fail_vec  (fail_vec1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a run on dut and follow it edge by edge. n is the number of edges
    // from the start edge to the first done cycle. p is the number of edges per
    // vector. When hold is set, start stays high afterwards.
    task automatic run_dut(input string name, input int n, input int p, input logic hold,
                           input logic [2:0] exp_err, input logic [3:0] exp_fail,
                           input logic [1:0] exp_ab);
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        check({name, "_start_busy"}, busy, 1);
        check({name, "_start_ab"}, {a, b}, 0);
        for (int k = 1; k <= n; k++) begin
            tick();
            if (k < n) begin
                if (busy !== 1'b1 || done !== 1'b0 || {a, b} !== 2'(k / p))
                    check({name, "_mid_ab_busy"}, {done, busy, a, b}, {2'b01, 2'(k / p)});
            end
        end
        check({name, "_done"}, {busy, done}, 2'b01);
        check({name, "_err"}, err_count, exp_err);
        check({name, "_fail"}, fail_vec, exp_fail);
        check({name, "_pass"}, pass, (exp_err == 3'd0));
        check({name, "_ab_end"}, {a, b}, exp_ab);
        $display("run %s: done after %0d edges err=%0d fail_vec=%b pass=%0d",
                 name, n, err_count, fail_vec, pass);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        gate_mode = 0;
        start     = 1'b0;
        start1    = 1'b0;
        reset     = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_outs", {a, b, busy, done, pass}, 0);
        check("rst_err", err_count, 0);
        check("rst_fail", fail_vec, 0);
        reset = 1'b0;

        // Correct gate, full clean run (start on first edge after reset)
        run_dut("clean", 20, 5, 1'b0, 3'd0, 4'b0000, 2'b11);

        // Stuck-at-0 gate
        gate_mode = 1;
`ifdef XOR_BIST_ABORT_EN
        run_dut("stuck0", 10, 5, 1'b0, 3'd1, 4'b0010, 2'b01);
`else
        run_dut("stuck0", 20, 5, 1'b0, 3'd2, 4'b0110, 2'b11);
`endif
        // Results hold in DONE while start is low and dut_out moves around
        gate_mode = 2;
        for (int k = 0; k < 3; k++) tick();
`ifdef XOR_BIST_ABORT_EN
        check("hold_res", {done, pass, err_count, fail_vec}, {1'b1, 1'b0, 3'd1, 4'b0010});
`else
        check("hold_res", {done, pass, err_count, fail_vec}, {1'b1, 1'b0, 3'd2, 4'b0110});
`endif

        // Reset during the third SETTLE (vector 10 loaded on edge 10)
        gate_mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 11; k++) tick();
        check("pre_rst_ab", {busy, a, b}, 3'b110);
        reset = 1'b1;
        start = 1'b1;
        tick();
        check("mid_rst_outs", {a, b, busy, done, pass}, 0);
        check("mid_rst_res", {err_count, fail_vec}, 0);
        reset = 1'b0;
        start = 1'b0;
        run_dut("after_rst", 20, 5, 1'b0, 3'd0, 4'b0000, 2'b11);

        // start held through a stuck-0 run, then restart from DONE
        gate_mode = 1;
`ifdef XOR_BIST_ABORT_EN
        run_dut("held", 10, 5, 1'b1, 3'd1, 4'b0010, 2'b01);
`else
        run_dut("held", 20, 5, 1'b1, 3'd2, 4'b0110, 2'b11);
`endif
        tick();
        check("restart_state", {busy, done, pass, a, b}, 5'b10000);
        check("restart_clr", {err_count, fail_vec}, 0);
        start = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // SETTLE_CYCLES=1 instance with an xnor gate
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("s1_start", {busy1, a1, b1}, 3'b100);
`ifdef XOR_BIST_ABORT_EN
        tick();
        check("s1_mid", {busy1, done1}, 2'b10);
        tick();
        check("s1_done", {busy1, done1}, 2'b01);
        check("s1_err", err_count1, 1);
        check("s1_fail", fail_vec1, 4'b0001);
        check("s1_ab", {a1, b1}, 2'b00);
`else
        for (int k = 1; k < 8; k++) begin
            tick();
            if (done1 !== 1'b0 || {a1, b1} !== 2'(k / 2))
                check("s1_mid", {done1, a1, b1}, {1'b0, 2'(k / 2)});
        end
        tick();
        check("s1_done", {busy1, done1}, 2'b01);
        check("s1_err", err_count1, 4);
        check("s1_fail", fail_vec1, 4'b1111);
        check("s1_ab", {a1, b1}, 2'b11);
`endif
        check("s1_pass", pass1, 0);
        $display("run s1_xnor: err=%0d fail_vec=%b", err_count1, fail_vec1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/xor_bist_checker.md
XOR_BIST_CHECKER -- requirements
Module: xor_bist_checker

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 4, number of settle cycles after each stimulus update before the check cycle; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 start  input  1  run request; sampled only in IDLE or DONE.
REQ-005 dut_out  input  1  response from the two-input XOR under test.
REQ-006 a  output  1  stimulus bit A to the DUT; registered.
REQ-007 b  output  1  stimulus bit B to the DUT; registered.
REQ-008 busy  output  1  high while in SETTLE or CHECK.
REQ-009 done  output  1  high while in DONE.
REQ-010 pass  output  1  high when done=1 and err_count=0.
REQ-011 err_count  output  3  number of mismatching vectors in the last run, 0..4.
REQ-012 fail_vec  output  4  bit i set when vector i mismatched; i = {a,b}.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, SETTLE, CHECK and DONE.
REQ-014 The vector order SHALL be idx 0..3 with a=idx[1] and b=idx[0], giving the sequence 00, 01, 10, 11.
REQ-015 In IDLE or DONE, start=1 SHALL load idx=0 and a=b=0, clear err_count, fail_vec and the settle counter, and enter SETTLE on the same edge.
REQ-016 SETTLE SHALL increment an 8-bit counter each cycle and enter CHECK on the edge where counter=SETTLE_CYCLES-1.
REQ-017 CHECK SHALL last one cycle; on its ending edge, dut_out SHALL be compared with a^b. The sample edge is SETTLE_CYCLES+1 edges after a/b were updated.
REQ-018 On a mismatch in CHECK, err_count SHALL increment by 1 and fail_vec[idx] SHALL be set, both on the same edge.
REQ-019 On the CHECK edge with idx<3, the block SHALL increment idx, update a/b to the new vector, clear the counter and return to SETTLE.
REQ-020 On the CHECK edge with idx=3, the block SHALL enter DONE; a and b SHALL hold at 1,1.
REQ-021 One full run SHALL take exactly 4*(SETTLE_CYCLES+1) cycles from the start edge to the first cycle with done=1.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 DONE SHALL hold err_count, fail_vec and pass stable until the next accepted start or reset.
REQ-024 start=1 in DONE SHALL restart a run on that edge; done SHALL drop in the next cycle.
REQ-025 err_count SHALL never exceed 4 and SHALL NOT wrap.
REQ-026 dut_out SHALL be ignored in every state except CHECK.

Reset
REQ-027 With reset=1 at a rising edge, the block SHALL enter IDLE with a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, idx=0 and counter=0.
REQ-028 Reset SHALL take priority over start and over any in-progress run, including a run in CHECK; no partial results SHALL be retained.
REQ-029 The first accepted start SHALL be on the first edge after reset deasserts.

Configuration
REQ-030 The macro XOR_BIST_ABORT_EN SHALL select the behaviour on the first mismatch.
REQ-031 With XOR_BIST_ABORT_EN defined, the first mismatching CHECK SHALL enter DONE immediately with err_count=1 and only that fail_vec bit set; a/b SHALL hold the failing vector.
REQ-032 With XOR_BIST_ABORT_EN undefined, all four vectors SHALL always be checked, as specified in REQ-019 and REQ-020.

Verification
REQ-033 Correct XOR DUT, SETTLE_CYCLES=4, start pulse -> a/b step 00,01,10,11 every 5 cycles; done=1 exactly 20 cycles after start; pass=1, err_count=0, fail_vec=0000.
REQ-034 dut_out tied to 0, abort undefined -> done after 20 cycles; err_count=2, fail_vec=0110, pass=0.
REQ-035 dut_out tied to 0, XOR_BIST_ABORT_EN defined -> done 10 cycles after start; err_count=1, fail_vec=0010, a=0, b=1.
REQ-036 Correct DUT, reset asserted during the third SETTLE -> next edge shows IDLE with all outputs 0; a following start gives a full clean run with pass=1.
REQ-037 start held high through a run, then in DONE -> no restart during busy; a new run begins on the DONE edge; results from the prior run are cleared at that edge.
REQ-038 SETTLE_CYCLES=1, DUT output inverted (XNOR) -> done 8 cycles after start; err_count=4, fail_vec=1111.
